// File: rtl/mmio_gpio_bank_if.sv
// Data-bus port of the GPIO bank: one-cycle read/write strobes,
// registered read data with a valid pulse.
interface mmio_gpio_bank_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              we;
  logic              re;
  logic [31:0]       rdata;
  logic              rvalid;

  modport master (
    output addr, wdata, we, re,
    input  rdata, rvalid
  );

  modport slave (
    input  addr, wdata, we, re,
    output rdata, rvalid
  );
endinterface

// File: rtl/mmio_gpio_bank.sv
// Memory-mapped GPIO bank: N_CH channels of OUT/IN/IEN/PEND registers,
// synchronised inputs, armed rising-edge capture and a level IRQ.
module mmio_gpio_bank #(
  parameter int WIDTH  = 16,
  parameter int N_CH   = 2,
  parameter int ADDR_W = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  mmio_gpio_bank_if.slave       bus,
  input  logic [N_CH*WIDTH-1:0] DIN,
  output logic [N_CH*WIDTH-1:0] DOUT,
  output logic                  IRQ
);

  localparam int NB   = N_CH * WIDTH;
  localparam int CH_W = ADDR_W - 4;
  localparam logic [31:0] NCH = 32'(N_CH);

  logic [NB-1:0] out_r;
  logic [NB-1:0] ien_r;
  logic [NB-1:0] pend_r;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] prev;
  logic [NB-1:0] rise;
  logic [NB-1:0] clr;
  logic [1:0]    warm;
  logic          armed;

  logic [CH_W-1:0] ch;
  logic [31:0]     ch32;
  logic [1:0]      rsel;
  logic            hit;
  logic [31:0]     rd_word;
  logic [31:0]     rdata_r;
  logic            rvalid_r;
  logic            unused_ok;

  assign ch    = bus.addr[ADDR_W-1:4];
  assign ch32  = 32'(ch);
  assign rsel  = bus.addr[3:2];
  assign hit   = ch32 < NCH;
  assign armed = warm == 2'd3;
  assign rise  = sync2 & ~prev & {NB{armed}};

  assign unused_ok = ^{bus.wdata, bus.addr[1:0]};

  always_comb begin
    rd_word = '0;
    clr     = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (hit && ch32 == 32'(c)) begin
        unique case (rsel)
          2'd0: rd_word = 32'(out_r[c*WIDTH +: WIDTH]);
          2'd1: rd_word = 32'(sync2[c*WIDTH +: WIDTH]);
          2'd2: rd_word = 32'(ien_r[c*WIDTH +: WIDTH]);
          2'd3: rd_word = 32'(pend_r[c*WIDTH +: WIDTH]);
          default: rd_word = '0;
        endcase
        if (bus.we && rsel == 2'd3)
          clr[c*WIDTH +: WIDTH] = bus.wdata[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      out_r    <= '0;
      ien_r    <= '0;
      pend_r   <= '0;
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      warm     <= '0;
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (bus.we && hit && ch32 == 32'(c)) begin
          if (rsel == 2'd0)
            out_r[c*WIDTH +: WIDTH] <= bus.wdata[WIDTH-1:0];
          if (rsel == 2'd2)
            ien_r[c*WIDTH +: WIDTH] <= bus.wdata[WIDTH-1:0];
        end
      end
      // set beats clear when both hit the same bit
      pend_r <= (pend_r & ~clr) | rise;
      sync1  <= DIN;
      sync2  <= sync1;
      prev   <= sync2;
      if (!armed)
        warm <= warm + 2'd1;
      rvalid_r <= bus.re;
      if (bus.re)
        rdata_r <= rd_word;
    end
  end

  assign DOUT       = out_r;
  assign IRQ        = |(pend_r & ien_r);
  assign bus.rdata  = rdata_r;
  assign bus.rvalid = rvalid_r;

endmodule

// File: doc/mmio_gpio_bank.md
Name: mmio_gpio_bank

Overview:
- Parametrised memory-mapped parallel I/O bank for the RISC-V core's data bus. Replaces the fixed 16-bit DIN/DOUT pair with N_CH independent channels of WIDTH bits each.
- Adds input synchronisation, rising-edge detection, per-bit interrupt enable and sticky pending flags (write-1-to-clear), and a registered one-cycle-latency read port.
- Sits between the core's load/store path and the external pins; IRQ goes to the core's external interrupt input.

Parameters:
- WIDTH, 16, bits per channel (1..32).
- N_CH, 2, number of channels (1..16).
- ADDR_W, 8, bus address width; must be >= 4 + clog2(N_CH).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- bus_addr  in  ADDR_W  byte address, word-aligned (bits [1:0] ignored).
- bus_wdata  in  32  write data.
- bus_we  in  1  write strobe, one cycle.
- bus_re  in  1  read strobe, one cycle.
- bus_rdata  out  32  read data, valid when bus_rvalid=1.
- bus_rvalid  out  1  read-data valid pulse.
- DIN  in  N_CH*WIDTH  asynchronous pin inputs; channel c occupies [c*WIDTH +: WIDTH].
- DOUT  out  N_CH*WIDTH  pin outputs, same packing as DIN.
- IRQ  out  1  level interrupt request.

Behaviour:
- Reset (RESET_N=0 at a CLK edge) clears: DOUT, all enables, all pending flags, both sync stages, prev, bus_rdata, bus_rvalid, warm-up counter. IRQ=0.
- Address decode: ch = bus_addr[ADDR_W-1:4], reg = bus_addr[3:2].
- Register map (per channel):
  - reg0 OUT: RW, drives DOUT.
  - reg1 IN: RO, synchronised DIN.
  - reg2 IEN: RW, per-bit interrupt enable.
  - reg3 PEND: read returns pending flags; a write clears each bit where wdata=1 (W1C).
- Width rules: writes use wdata[WIDTH-1:0]; reads zero-extend to 32 bits. ch >= N_CH: reads return 0 with bus_rvalid still pulsed; writes are ignored. Writes to IN are ignored.
- Write timing: a write takes effect at the CLK edge where bus_we=1. DOUT changes on that same edge (zero added latency).
- Read timing:
  - bus_re=1 at edge k: bus_rdata is loaded with the pre-edge register value and bus_rvalid=1 during cycle k..k+1. bus_rvalid drops at edge k+1 unless bus_re is asserted again.
  - bus_rdata holds its value until the next read.
  - Back-to-back reads are allowed every cycle.
- Same-cycle read and write to the same register: the read returns the old value.
- Synchroniser: 2 flops per input bit (sync1 <- DIN, sync2 <- sync1). IN reads sync2. prev <- sync2 each cycle.
- Edge detect: rise = sync2 & ~prev, gated by armed. A DIN change sampled at edge k appears in sync2 after edge k+1; its PEND bit sets at edge k+2.
- Warm-up: a 2-bit counter counts 0..3 after reset release and saturates; armed = (count==3). Inputs high across reset therefore never raise spurious pending flags.
- Pending: pend_next = (pend & ~w1c_mask) | rise. If a set and a clear hit the same bit on the same edge, the set wins. Pending flags set regardless of IEN.
- IRQ = OR over all channels of (PEND & IEN). Driven from registers only, so it has no combinational path from the bus or DIN. It asserts in the same cycle PEND or IEN updates, and deasserts the cycle after the clearing write.
- Reset mid-read: bus_rvalid=0 on the reset edge. A read issued during reset returns nothing.

Test Plan:
- Reset with DIN all ones, hold 10 cycles after release -> IN reads 0xFFFF on ch0 and ch1 (WIDTH=16), PEND=0, IRQ=0.
- Write 0xA5A5 to ch1 OUT (addr 0x10) -> DOUT[31:16]=0xA5A5 after that edge and DOUT[15:0] unchanged; a read of 0x10 returns 0x0000A5A5 with bus_rvalid one cycle after bus_re.
- IEN ch0 = 0x0001; DIN[0] rises at edge k -> PEND ch0 bit0 set at k+2 and IRQ=1 the same cycle; writing 0x0001 to 0x0C drops IRQ; writing 0x0000 leaves IRQ high.
- W1C write of 0x0004 to ch0 PEND on the same edge a new rise of bit2 is registered -> bit2 stays 1.
- Read and write to ch0 OUT in the same cycle (old 0x1234, new 0x5678) -> bus_rdata=0x1234; the next read returns 0x5678. Read of an out-of-range channel (addr 0x20, N_CH=2) -> 0 with bus_rvalid=1.
- Assert RESET_N=0 one cycle after bus_re -> bus_rvalid=0, DOUT=0, IRQ=0 on the reset edge.
